// File: rtl/pwm_shadow_commit_sched_if.sv
// Software-side bus of the PWM shadow/commit scheduler.
// Carries the shadow-register write handshake and the commit
// request/status handshake between the register file (master)
// and the scheduler (slave).
//   wr_valid/wr_ready/wr_ch/wr_field/wr_data : shadow write
//   commit_req/commit_mask                   : commit request
//   commit_busy/commit_done/commit_timeout   : commit status
interface pwm_shadow_commit_sched_if #(
    parameter int N_CH = 8,
    parameter int CW   = 16
);
    logic                    wr_valid;
    logic                    wr_ready;
    logic [$clog2(N_CH)-1:0] wr_ch;
    logic [1:0]              wr_field;
    logic [CW-1:0]           wr_data;
    logic                    commit_req;
    logic [N_CH-1:0]         commit_mask;
    logic                    commit_busy;
    logic                    commit_done;
    logic                    commit_timeout;

    modport master (
        output wr_valid, wr_ch, wr_field, wr_data, commit_req, commit_mask,
        input  wr_ready, commit_busy, commit_done, commit_timeout
    );

    modport slave (
        input  wr_valid, wr_ch, wr_field, wr_data, commit_req, commit_mask,
        output wr_ready, commit_busy, commit_done, commit_timeout
    );
endinterface

// File: rtl/pwm_shadow_commit_sched.sv
// Per-channel shadow/active configuration scheduler for the PWM core.
// Writes land in shadow registers; a commit arms a channel mask and each
// armed channel copies its shadow set to its active outputs on its own
// carrier boundary pulse. A timeout forces whatever is still pending.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   cfg          : write + commit bus (slave side)
//   sync_evt_x   : per-channel carrier boundary pulse
//   load_x       : per-channel pulse, active set just changed
//   period_x, compare_x, initcarr_x (CW per channel), dtime_x (DTW per
//   channel) : active values, channel i at [W*i +: W]
module pwm_shadow_commit_sched #(
    parameter int N_CH    = 8,
    parameter int CW      = 16,
    parameter int DTW     = 10,
    parameter int TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    pwm_shadow_commit_sched_if.slave cfg,
    input  logic [N_CH-1:0]      sync_evt_x,
    output logic [N_CH-1:0]      load_x,
    output logic [CW*N_CH-1:0]   period_x,
    output logic [CW*N_CH-1:0]   compare_x,
    output logic [CW*N_CH-1:0]   initcarr_x,
    output logic [DTW*N_CH-1:0]  dtime_x
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

    state_t state, state_nxt;

    logic [N_CH-1:0][CW-1:0]  sh_period, sh_compare, sh_initcarr;
    logic [N_CH-1:0][DTW-1:0] sh_dtime;
    logic [N_CH-1:0]          pending;
    logic [CNT_W-1:0]         cnt;
    logic                     tmo_flag;

    logic [N_CH-1:0]          hit, copy;
    logic                     force_tmo;
    logic                     wr_take;

    // Out-of-range channels (non power-of-2 N_CH) are accepted but dropped.
    assign wr_take = cfg.wr_valid && cfg.wr_ready && (int'(cfg.wr_ch) < N_CH);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic. ARMED leaves only once the registered pending mask
    // is empty, so commit_done lands one cycle after the last copy.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg.commit_req)
                         state_nxt = (cfg.commit_mask != '0) ? ARMED : DONE;
            ARMED:   if (pending == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state register only
    always_comb begin
        cfg.wr_ready       = (state == IDLE);
        cfg.commit_busy    = (state == ARMED) || (state == DONE);
        cfg.commit_done    = (state == DONE);
        cfg.commit_timeout = (state == DONE) && tmo_flag;
    end

    // Channels to copy this cycle: evented ones, plus every remaining
    // pending channel once the timeout count is reached. An event that
    // clears the last pending channel on the timeout cycle is not a timeout.
    always_comb begin
        hit       = pending & sync_evt_x;
        copy      = hit;
        force_tmo = 1'b0;
        if (cnt == CNT_W'(TIMEOUT - 1) && (pending & ~hit) != '0) begin
            copy      = pending;
            force_tmo = 1'b1;
        end
    end

    // Datapath: shadow writes, commit arming, active copies
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_period   <= '0;
            sh_compare  <= '0;
            sh_initcarr <= '0;
            sh_dtime    <= '0;
            period_x    <= '0;
            compare_x   <= '0;
            initcarr_x  <= '0;
            dtime_x     <= '0;
            pending     <= '0;
            cnt         <= '0;
            tmo_flag    <= 1'b0;
            load_x      <= '0;
        end else begin
            load_x <= '0;
            if (wr_take) begin
                case (cfg.wr_field)
                    2'd0: sh_period[cfg.wr_ch]   <= cfg.wr_data;
                    2'd1: sh_compare[cfg.wr_ch]  <= cfg.wr_data;
                    2'd2: sh_initcarr[cfg.wr_ch] <= cfg.wr_data;
                    default: sh_dtime[cfg.wr_ch] <= cfg.wr_data[DTW-1:0];
                endcase
            end
            case (state)
                IDLE: begin
                    if (cfg.commit_req) begin
                        pending  <= cfg.commit_mask;
                        cnt      <= '0;
                        tmo_flag <= 1'b0;
                    end
                end
                ARMED: begin
                    if (pending != '0) begin
                        for (int i = 0; i < N_CH; i++) begin
                            if (copy[i]) begin
                                period_x[CW*i +: CW]   <= sh_period[i];
                                compare_x[CW*i +: CW]  <= sh_compare[i];
                                initcarr_x[CW*i +: CW] <= sh_initcarr[i];
                                dtime_x[DTW*i +: DTW]  <= sh_dtime[i];
                            end
                        end
                        load_x  <= copy;
                        pending <= pending & ~copy;
                        cnt     <= cnt + 1'b1;
                        if (force_tmo) tmo_flag <= 1'b1;
                    end
                end
                DONE:    tmo_flag <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
